alu_result_sequencer: RTL and testbench

Control stage directly upstream of the ALU 5-input result mux. Accepts one ALU command per valid/ready handshake and decodes it into the mux select lines (s0, s1, s2) and lane modifiers (invert, carry-in). It then waits a fixed number of cycles for the gate-delay datapath to settle, and registers the muxed result behind a valid/ready output handshake. One command is in flight at a time.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_cmd_decode.sv | 18 +
 rtl/alu_result_sequencer.sv | 80 ++++++++
 tb/tb_alu_result_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared command codes, lane select codes and FSM state encoding for the ALU result sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_SUB  = 3'b001,
    CMD_XOR  = 3'b010,
    CMD_SLT  = 3'b011,
    CMD_AND  = 3'b100,
    CMD_NAND = 3'b101,
    CMD_NOR  = 3'b110,
    CMD_OR   = 3'b111
  } cmd_e;
  localparam logic [2:0] LANE_ADD = 3'b000;
  localparam logic [2:0] LANE_XOR = 3'b001;
  localparam logic [2:0] LANE_SLT = 3'b010;
  localparam logic [2:0] LANE_AND = 3'b011;
  localparam logic [2:0] LANE_OR  = 3'b100;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_e;
endpackage

// File: rtl/alu_cmd_decode.sv
// alu_cmd_decode: combinational ALU command to {s0,s1,s2} lane select plus invert/carry-in modifiers
// Ports: cmd (3-bit command) -> lane ({s0,s1,s2}), op_invert, op_cin
module alu_cmd_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] cmd,
  output logic [2:0] lane,
  output logic       op_invert,
  output logic       op_cin
);
  // the 100 lane natively computes NOR, so OR is the inverted variant
  assign lane = (cmd == CMD_ADD || cmd == CMD_SUB) ? LANE_ADD :
                (cmd == CMD_XOR)                   ? LANE_XOR :
                (cmd == CMD_SLT)                   ? LANE_SLT :
                (cmd == CMD_AND || cmd == CMD_NAND) ? LANE_AND : LANE_OR;
  assign op_invert = cmd == CMD_SUB || cmd == CMD_SLT || cmd == CMD_NAND || cmd == CMD_OR;
  assign op_cin    = cmd == CMD_SUB || cmd == CMD_SLT;
endmodule

// File: rtl/alu_result_sequencer.sv
// alu_result_sequencer: accepts one ALU command, drives mux selects, waits SETTLE_CYCLES, registers the result
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd in; sel_s0..2, op_invert, op_cin out;
//        mux_out in; res_valid/res_ready/res_data out; res_zero out when ALU_SEQ_ZERO_FLAG_EN is defined
module alu_result_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  output logic             sel_s0,
  output logic             sel_s1,
  output logic             sel_s2,
  output logic             op_invert,
  output logic             op_cin,
  input  logic [WIDTH-1:0] mux_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic             res_zero
`endif
);
  state_e     state, state_nx;
  logic [3:0] cnt;
  logic [2:0] sel, dec_lane;
  logic       dec_inv, dec_cin, accept;
  alu_cmd_decode u_dec (.cmd(cmd), .lane(dec_lane), .op_invert(dec_inv), .op_cin(dec_cin));
  assign {sel_s0, sel_s1, sel_s2} = sel;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_ready && cmd_valid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? SETTLE : IDLE;
      SETTLE:  state_nx = cnt == '0 ? CAPTURE : SETTLE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      op_invert <= 1'b0;
      op_cin    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sel       <= dec_lane;
        op_invert <= dec_inv;
        op_cin    <= dec_cin;
        cnt       <= 4'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == CAPTURE) begin
        res_data  <= mux_out;
        res_valid <= 1'b1;
      end else if (state == DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
`ifdef ALU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_zero <= 1'b0;
    else if (state == CAPTURE) res_zero <= mux_out == '0;
  end
`endif
endmodule

// File: tb/tb_alu_result_sequencer.sv
// tb_alu_result_sequencer: directed plus randomized bench checked against a transaction-level model
module tb_alu_result_sequencer;
  localparam int WIDTH = 32;
  localparam int SETTLE = 4;
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd = '0;
  logic             sel_s0, sel_s1, sel_s2, op_invert, op_cin;
  logic [WIDTH-1:0] mux_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             res_zero;
`endif
  int checks = 0;
  int errors = 0;
  alu_result_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .sel_s0(sel_s0), .sel_s1(sel_s1), .sel_s2(sel_s2), .op_invert(op_invert), .op_cin(op_cin),
    .mux_out(mux_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .res_zero(res_zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected {lane[2:0], invert, cin} per command, straight from the decode table
  logic [4:0] dec_tab [8] = '{5'b000_0_0, 5'b000_1_1, 5'b001_0_0, 5'b010_1_1,
                              5'b011_0_0, 5'b011_1_0, 5'b100_0_0, 5'b100_1_0};
  // Transaction-level model: a command is either absent, settling, or holding a result
  int         cyc = 0, acc_cyc = 0;
  logic       m_busy = 0, m_valid = 0, m_zero = 0, m_inv = 0, m_cin = 0;
  logic [2:0] m_sel = '0;
  logic [WIDTH-1:0] m_data = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_busy = 0; m_valid = 0; m_zero = 0; m_inv = 0; m_cin = 0; m_sel = '0; m_data = '0;
    end else begin
      cyc++;
      if (m_valid && res_ready) begin
        m_valid = 0;
        m_busy = 0;
      end else if (m_busy && !m_valid && cyc == acc_cyc + SETTLE + 1) begin
        m_valid = 1;
        m_data = mux_out;
        m_zero = mux_out == 0;
      end else if (!m_busy && cmd_valid) begin
        m_busy = 1;
        acc_cyc = cyc;
        {m_sel, m_inv, m_cin} = dec_tab[cmd];
      end
    end
  end
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("sel", {sel_s0, sel_s1, sel_s2}, m_sel);
    chk("op_invert", op_invert, m_inv);
    chk("op_cin", op_cin, m_cin);
    chk("res_valid", res_valid, m_valid);
    chk("res_data", res_data, m_data);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("res_zero", res_zero, m_zero);
`endif
  end
  task automatic step(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] m, input logic r);
    cmd_valid = v; cmd = c; mux_out = m; res_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_sel", {sel_s0, sel_s1, sel_s2}, 3'b000);
    chk("rst_inv_cin", {op_invert, op_cin}, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, '0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    async_reset_check();
    step(0, 3'd0, '0, 1);
    // NAND with a fixed mux value
    step(1, 3'b101, 32'h0000_00F0, 1);
    repeat (8) step(0, 3'd0, 32'h0000_00F0, 1);
    // SUB, with NOR offered while busy
    step(1, 3'b001, $urandom, 1);
    repeat (12) step(1, 3'b110, $urandom, 1);
    step(0, 3'd0, $urandom, 1);
    repeat (8) step(0, 3'd0, $urandom, 1);
    // result held while res_ready is low, then a single pulse
    step(1, 3'b111, $urandom, 0);
    repeat (26) step(1, 3'b000, $urandom, 0);
    step(0, 3'd0, $urandom, 1);
    repeat (3) step(0, 3'd0, $urandom, 0);
    step(0, 3'd0, $urandom, 1);
    // reset during SETTLE of SLT, then a normal command
    step(1, 3'b011, $urandom, 1);
    step(0, 3'd0, $urandom, 1);
    async_reset_check();
    repeat (8) step(0, 3'd0, $urandom, 1);
    step(1, 3'b100, $urandom, 1);
    repeat (8) step(0, 3'd0, $urandom, 1);
    // zero flag: XOR with zero then nonzero result
    step(1, 3'b010, '0, 1);
    repeat (7) step(0, 3'd0, '0, 1);
    step(1, 3'b010, 32'h1, 1);
    repeat (7) step(0, 3'd0, 32'h1, 1);
    // randomized traffic, occasionally with zero results and a stray reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset_check();
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom), $urandom_range(0, 9) < 7);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
